// File: rtl/fetch_sequencer_if.sv
// Bundle of host control, datapath branch resolution and fetch_unit control
// signals seen by fetch_sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned width = 9,
  parameter int unsigned CNT_W = 16
);
  logic              go;
  logic [1:0]        prog_sel;
  logic              abort;
  logic [width-1:0]  instr_in;
  logic              branch_in;
  logic              taken_in;
  logic [width-1:0]  target_in;
  logic              fu_start;
  logic [width-1:0]  fu_start_addr;
  logic              fu_branch;
  logic              fu_taken;
  logic [width-1:0]  fu_target;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  // Host / datapath side
  modport master (
    output go, prog_sel, abort, instr_in, branch_in, taken_in, target_in,
    input  fu_start, fu_start_addr, fu_branch, fu_taken, fu_target,
           busy, done, timeout, cycle_count
  );

  // Sequencer side
  modport slave (
    input  go, prog_sel, abort, instr_in, branch_in, taken_in, target_in,
    output fu_start, fu_start_addr, fu_branch, fu_taken, fu_target,
           busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Sequences fetch_unit through launch, start-address load, run and halt/timeout
// detection, gating datapath branch controls through only while running.
module fetch_sequencer #(
  parameter int unsigned width       = 9,
  parameter int unsigned LOAD_CYCLES = 3,
  parameter logic [8:0]  HALT_OP     = 9'h1FF,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ADDR0       = 0,
  parameter int unsigned ADDR1       = 16,
  parameter int unsigned ADDR2       = 64,
  parameter int unsigned ADDR3       = 128
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.slave   bus
);

  localparam int unsigned LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_q;
  logic [LC_W-1:0]    load_cnt_q;
  logic [width-1:0]   start_addr_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic               timeout_q;
  logic               fu_start_q;
  logic               busy_q;
  logic               done_q;

  logic [width-1:0]   sel_addr_d;
  logic [CNT_W-1:0]   cnt_inc_d;
  logic               halt_d;
  logic               budget_d;
  logic               run_c;

  // Entry address for the requested program
  always_comb begin
    sel_addr_d = width'(ADDR0);
    case (bus.prog_sel)
      2'd0:    sel_addr_d = width'(ADDR0);
      2'd1:    sel_addr_d = width'(ADDR1);
      2'd2:    sel_addr_d = width'(ADDR2);
      default: sel_addr_d = width'(ADDR3);
    endcase
  end

  // Saturating run-cycle increment and end-of-run conditions
  always_comb begin
    cnt_inc_d = (cycle_count_q == {CNT_W{1'b1}}) ? cycle_count_q
                                                  : cycle_count_q + CNT_W'(1);
    halt_d    = (bus.instr_in == width'(HALT_OP));
    budget_d  = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      start_addr_q  <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      fu_start_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            state_q       <= ST_LOAD;
            load_cnt_q    <= LC_W'(LOAD_CYCLES - 1);
            start_addr_q  <= sel_addr_d;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            fu_start_q    <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state_q    <= ST_IDLE;
            fu_start_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (load_cnt_q == '0) begin
            state_q    <= ST_RUN;
            fu_start_q <= 1'b0;
          end else begin
            load_cnt_q <= load_cnt_q - LC_W'(1);
          end
        end
        ST_RUN: begin
          // The exiting edge still counts as a RUN cycle, even on abort
          cycle_count_q <= cnt_inc_d;
          if (bus.abort) begin
            state_q    <= ST_IDLE;
            fu_start_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (halt_d) begin
            state_q    <= ST_DONE;
            fu_start_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (budget_d) begin
            state_q    <= ST_DONE;
            timeout_q  <= 1'b1;
            fu_start_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          fu_start_q <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          fu_start_q <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign run_c = (state_q == ST_RUN);

  assign bus.fu_start      = fu_start_q;
  assign bus.fu_start_addr = start_addr_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
  assign bus.cycle_count   = cycle_count_q;

  // Branch controls reach fetch_unit only while running
  assign bus.fu_branch = run_c & bus.branch_in;
  assign bus.fu_taken  = run_c & bus.taken_in;
  assign bus.fu_target = run_c ? bus.target_in : '0;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences `fetch_unit` through a complete program run. It accepts a launch request, selects one of four program entry addresses, and holds `fetch_unit` in its start/load condition for a fixed number of cycles. It then releases the PC, gates the datapath's branch signals through, and detects program end on a HALT instruction or a cycle-budget timeout. It sits between the top-level test/host control and `fetch_unit`; the datapath's branch resolution passes through it.

## Interface
- `width`, 9: instruction and address width (matches `fetch_unit`)
- `LOAD_CYCLES`, 3: cycles `fu_start` is held high after launch (≥1)
- `HALT_OP`, 9'h1FF: instruction encoding that ends a run
- `MAX_CYCLES`, 1000: RUN-cycle budget before timeout (≥1, < 2^CNT_W)
- `CNT_W`, 16: cycle counter width
- `ADDR0`/`ADDR1`/`ADDR2`/`ADDR3`, 0/16/64/128: entry addresses for `prog_sel` 0–3

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `go`  in  1  launch request, sampled only in IDLE
- `prog_sel`  in  2  entry-address select, sampled with `go`
- `abort`  in  1  cancel current run
- `instr_in`  in  width  `fetch_unit.instr_out`
- `branch_in`, `taken_in`  in  1 each  datapath branch resolution
- `target_in`  in  width  datapath branch target
- `fu_start`  out  1  to `fetch_unit.start`
- `fu_start_addr`  out  width  to `fetch_unit.start_addr` (registered)
- `fu_branch`, `fu_taken`  out  1 each  gated branch controls
- `fu_target`  out  width  gated target
- `busy`  out  1  high in LOAD or RUN
- `done`  out  1  high for the single DONE cycle
- `timeout`  out  1  sticky: last run ended by budget
- `cycle_count`  out  CNT_W  RUN cycles of current/last run

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE
  - `fu_start`=1, which keeps the PC frozen at `fu_start_addr`.
  - On `go`=1: latch `ADDR[prog_sel]` into `fu_start_addr`, clear `cycle_count` and `timeout`, load counter, go to LOAD.
- LOAD
  - `fu_start`=1 for exactly LOAD_CYCLES cycles, then go to RUN.
- RUN
  - `fu_start`=0.
  - `fu_branch`/`fu_taken`/`fu_target` are the combinational pass-through of `*_in`. In every other state they are forced to 0.
  - `cycle_count` increments on every RUN clock edge, including the exiting edge.
  - If `instr_in`==HALT_OP: go to DONE.
  - Otherwise, if `cycle_count`==MAX_CYCLES-1: set `timeout`=1 and go to DONE.
- DONE
  - One cycle, `done`=1, `fu_start`=1, then go to IDLE.
- `abort`
  - In LOAD or RUN: go to IDLE next edge. No `done`, `timeout` unchanged, `cycle_count` frozen at its current value.
  - Ignored in IDLE and DONE.
- `go` in LOAD, RUN or DONE is ignored and not queued.
- `fu_start_addr`, `cycle_count` and `timeout` hold their values after a run until the next accepted `go`.

## Timing
- Reset values: state IDLE; `fu_start`=1; `fu_start_addr`=0; `fu_branch`=`fu_taken`=0; `fu_target`=0; `busy`=0; `done`=0; `timeout`=0; `cycle_count`=0.
- Reset takes effect at any state on the next edge and overrides `go`/`abort`.
- `go` sampled at edge k: LOAD spans cycles k+1 … k+LOAD_CYCLES; RUN begins at cycle k+LOAD_CYCLES+1.
- HALT on the first RUN cycle gives `cycle_count`=1. The next cycle is DONE, and IDLE follows one cycle later.
- Timeout gives a final `cycle_count`=MAX_CYCLES.
- Priority within RUN: `abort` > HALT > timeout. HALT and budget expiring in the same cycle is a halt (`timeout`=0).
- `cycle_count` saturates at 2^CNT_W−1 and never wraps.
- All outputs except `fu_branch`/`fu_taken`/`fu_target` are registered or decoded directly from the state register.

## Test plan
- Reset: hold `reset` 2 cycles → all outputs at reset values, `fu_start`=1, `fu_start_addr`=0.
- Launch: `prog_sel`=1, `go` pulse → `fu_start_addr`=16; `fu_start` high exactly 3 cycles then low; `busy`=1 from the first LOAD cycle.
- Halt: drive `instr_in`=9'h1FF on the 5th RUN cycle → `done` one-cycle pulse, `cycle_count`=5, `timeout`=0, `busy`=0.
- Timeout: MAX_CYCLES=8, `instr_in` never HALT → `timeout`=1, `cycle_count`=8, `done` pulse; next `go` clears `timeout`.
- Branch gating:
  - In RUN, `branch_in`=`taken_in`=1, `target_in`=255 → `fu_*` mirror them the same cycle.
  - Same stimulus in LOAD or IDLE → `fu_*`=0.
- Abort/ignore:
  - `abort` in RUN cycle 3 → IDLE next cycle, no `done`, `cycle_count`=3.
  - `go` during RUN → no effect.
  - `reset` mid-LOAD → IDLE next edge with reset values.
